mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for the pipeline's single shared memory port. It accepts instruction-fetch requests from the IF stage and load/store requests from the MEM stage. It grants one transaction at a time, drives the memory port through a registered state machine, and returns data with a one-cycle done pulse. It also generates the pipeline freeze signals (PCWrite, IFIDWrite, MemStall) consumed alongside the hazard unit.

## Interface
- STARVE_MAX, 4: max consecutive data grants while a fetch is pending before the fetch is forced through (≥1)
- Clk  in  1  clock; all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- IFReq  in  1  fetch request; held high until IFDone
- IFAddr  in  32  fetch address; stable while IFReq high
- IFData  out  32  fetched instruction; valid in the IFDone cycle, held until next fetch completes
- IFDone  out  1  one-cycle completion pulse (registered)
- DReq  in  1  data request; held high until DDone
- DWrite  in  1  1 = store, 0 = load
- DAddr  in  32  data address
- DWData  in  32  store data
- DRData  out  32  load data; valid in the DDone cycle of a load, unchanged by stores
- DDone  out  1  one-cycle completion pulse (registered)
- MemEn  out  1  memory transaction active (registered)
- MemWe  out  1  write enable, meaningful only when MemEn = 1
- MemAddr  out  32  registered address, held for the whole transaction
- MemWData  out  32  registered store data
- MemRData  in  32  read data, sampled when MemValid = 1
- MemValid  in  1  memory completion/ack; may assert in any cycle MemEn = 1, including the first
- PCWrite  out  1  0 freezes PC
- IFIDWrite  out  1  0 freezes IF/ID register
- MemStall  out  1  1 freezes EX/MEM and all earlier stages

## Operation
- States: IDLE, I_BUSY, D_BUSY. Reset → IDLE. Reset values: MemEn=0, MemWe=0, MemAddr=0, MemWData=0, IFData=0, DRData=0, IFDone=0, DDone=0, starve_cnt=0.
- Arbitration occurs only in IDLE. A requester is eligible if its Req=1 and its Done=0 in the same cycle; the done cycle masks the stale request.
- Data has priority: if D is eligible and (I is not eligible or starve_cnt < STARVE_MAX), the arbiter goes to D_BUSY and latches DAddr/DWData/DWrite into MemAddr/MemWData/MemWe. Else if I is eligible, it goes to I_BUSY, latches IFAddr, and sets MemWe=0.
- starve_cnt: +1 on each D grant while I is eligible, saturating at STARVE_MAX; cleared on every I grant and whenever IFReq=0.
- I_BUSY/D_BUSY: MemEn=1 and memory outputs are held. On MemValid=1 the block goes to IDLE, MemEn=0, and the matching Done is set for one cycle. For I_BUSY, IFData←MemRData. For a D_BUSY load, DRData←MemRData.
- MemValid in IDLE is ignored.
- A request withdrawn mid-transaction does not abort it; the transaction completes and Done still pulses.
- Freeze logic (combinational):
  - HoldIF = IFReq & ~IFDone
  - HoldD = DReq & ~DDone
  - PCWrite = IFIDWrite = ~(HoldIF | HoldD)
  - MemStall = HoldD
- Reset asserted mid-transaction aborts immediately. MemEn drops asynchronously, no Done is issued, and the requester must reissue.

## Timing
- Request seen in IDLE at cycle 0 → MemEn=1 from cycle 1.
- MemValid at cycle 1+w (w ≥ 0 wait cycles) → Done and data at cycle 2+w.
- MemEn deasserts at cycle 2+w.
- Minimum request-to-done latency is 2 cycles.
- Back-to-back: IDLE lasts exactly one cycle between transactions, so one transaction completes per 3+w cycles.
- Simultaneous IFReq and DReq rising in IDLE → D granted first; I granted in the IDLE cycle after DDone.

## Test plan
- Fetch only, MemValid tied 1: IFReq at cycle 0, IFAddr=0x40 → MemEn cycles 1–1, MemAddr=0x40, IFDone=1 with IFData=MemRData at cycle 2, PCWrite=0 cycles 0–1, PCWrite=1 at cycle 2.
- Store, 3 wait cycles: DReq, DWrite=1, DAddr=0x100, DWData=0xDEADBEEF → MemEn/MemWe=1 cycles 1–4, DDone cycle 5, DRData unchanged, MemStall=1 cycles 0–4.
- Simultaneous IFReq+DReq (load), w=0 → D serviced first (DDone cycle 2), I granted cycle 3, IFDone cycle 5.
- Starvation, STARVE_MAX=4, DReq held continuously with new address each done, IFReq held → exactly 4 DDone pulses, then 1 IFDone, then starve_cnt=0.
- Rst_n low during D_BUSY cycle 2 → MemEn=0 immediately, no DDone, all outputs at reset values. After release with DReq still high → fresh grant, DDone 2 cycles later.
- Stray MemValid=1 in IDLE with no requests → no Done pulse, state stays IDLE, IFData/DRData unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Purpose: request, response and memory-port bundle between pipeline, arbiter and memory.
// Latency: wiring only; all timing is set by the arbiter.
// Backpressure: requests are held until their Done pulse; memory stretches via MemValid.
interface mem_port_arbiter_if;
  logic        IFReq;
  logic [31:0] IFAddr;
  logic [31:0] IFData;
  logic        IFDone;
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [31:0] DRData;
  logic        DDone;
  logic        MemEn;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemValid;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        MemStall;

  // Arbiter side
  modport slave (
    input  IFReq, IFAddr, DReq, DWrite, DAddr, DWData, MemRData, MemValid,
    output IFData, IFDone, DRData, DDone, MemEn, MemWe, MemAddr, MemWData,
           PCWrite, IFIDWrite, MemStall
  );

  // Pipeline + memory side
  modport master (
    output IFReq, IFAddr, DReq, DWrite, DAddr, DWData, MemRData, MemValid,
    input  IFData, IFDone, DRData, DDone, MemEn, MemWe, MemAddr, MemWData,
           PCWrite, IFIDWrite, MemStall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates IF fetches and MEM loads/stores onto one memory port, data first with a fetch starvation cap.
// Latency: request in IDLE -> MemEn next cycle -> Done one cycle after MemValid (min 2); one turnaround cycle after each Done.
// Backpressure: requesters hold Req until Done; pipeline is frozen through PCWrite/IFIDWrite/MemStall meanwhile.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic              Clk,
  input logic              Rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [SW-1:0] SONE = SW'(1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t        state_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   if_data_q;
  logic [31:0]   d_rdata_q;
  logic          if_done_q;
  logic          d_done_q;
  logic [SW-1:0] starve_q;

  logic i_elig;
  logic d_elig;
  logic turnaround;
  logic hold_if;
  logic hold_d;

  // A Done cycle masks its own stale request; it is also a turnaround cycle in
  // which no new grant is made, so IDLE is one full cycle between transactions.
  assign i_elig     = bus.IFReq & ~if_done_q;
  assign d_elig     = bus.DReq & ~d_done_q;
  assign turnaround = if_done_q | d_done_q;

  // Single registered FSM: arbitration in IDLE, hold the port while busy, pulse Done on MemValid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      starve_q    <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      if (!bus.IFReq) starve_q <= '0;
      case (state_q)
        IDLE: begin
          if (!turnaround) begin
            if (d_elig && (!i_elig || starve_q < SMAX)) begin
              state_q     <= D_BUSY;
              mem_en_q    <= 1'b1;
              mem_we_q    <= bus.DWrite;
              mem_addr_q  <= bus.DAddr;
              mem_wdata_q <= bus.DWData;
              // The grant condition already guarantees starve_q < SMAX here,
              // so the increment saturates at SMAX by construction.
              if (i_elig) starve_q <= starve_q + SONE;
            end else if (i_elig) begin
              state_q    <= I_BUSY;
              mem_en_q   <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= bus.IFAddr;
              starve_q   <= '0;
            end
          end
        end
        I_BUSY: begin
          if (bus.MemValid) begin
            state_q   <= IDLE;
            mem_en_q  <= 1'b0;
            if_done_q <= 1'b1;
            if_data_q <= bus.MemRData;
          end
        end
        D_BUSY: begin
          if (bus.MemValid) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            d_done_q <= 1'b1;
            if (!mem_we_q) d_rdata_q <= bus.MemRData;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pipeline freeze: hold fetch side while a fetch is outstanding, hold everything while data is outstanding.
  always_comb begin
    hold_if = bus.IFReq & ~if_done_q;
    hold_d  = bus.DReq & ~d_done_q;
  end

  assign bus.PCWrite   = ~(hold_if | hold_d);
  assign bus.IFIDWrite = ~(hold_if | hold_d);
  assign bus.MemStall  = hold_d;

  assign bus.MemEn    = mem_en_q;
  assign bus.MemWe    = mem_we_q;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWData = mem_wdata_q;
  assign bus.IFData   = if_data_q;
  assign bus.IFDone   = if_done_q;
  assign bus.DRData   = d_rdata_q;
  assign bus.DDone    = d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed checks of arbitration order, handshake timing, freeze outputs, starvation cap and reset abort.
// Latency: inputs driven and outputs sampled around the falling clock edge.
// Backpressure: memory model answers with MemRData = MemAddr ^ 0xA5A50000 whenever MemValid is driven high.
module tb_mem_port_arbiter;
  logic Clk;
  logic Rst_n;
  int   n_pass;
  int   n_chk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  assign bus.MemRData = bus.MemAddr ^ 32'hA5A5_0000;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
  endtask

  task automatic idle_inputs();
    bus.IFReq = 0; bus.IFAddr = 0; bus.DReq = 0; bus.DWrite = 0;
    bus.DAddr = 0; bus.DWData = 0; bus.MemValid = 0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    idle_inputs();
    @(negedge Clk); #1;
    n_chk++; if (bus.MemEn !== 1'b0 || bus.MemWe !== 1'b0) $display("FAIL rst_en_we: got %b%b want 00", bus.MemEn, bus.MemWe); else n_pass++;
    n_chk++; if (bus.MemAddr !== 32'h0 || bus.MemWData !== 32'h0) $display("FAIL rst_addr_wdata: got %h %h want 0 0", bus.MemAddr, bus.MemWData); else n_pass++;
    n_chk++; if (bus.IFData !== 32'h0 || bus.DRData !== 32'h0) $display("FAIL rst_data: got %h %h want 0 0", bus.IFData, bus.DRData); else n_pass++;
    n_chk++; if (bus.IFDone !== 1'b0 || bus.DDone !== 1'b0) $display("FAIL rst_done: got %b%b want 00", bus.IFDone, bus.DDone); else n_pass++;
    n_chk++; if (bus.PCWrite !== 1'b1 || bus.IFIDWrite !== 1'b1 || bus.MemStall !== 1'b0) $display("FAIL rst_freeze: got %b%b%b want 110", bus.PCWrite, bus.IFIDWrite, bus.MemStall); else n_pass++;
    @(negedge Clk); Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_fetch();
    @(negedge Clk); bus.IFReq = 1; bus.IFAddr = 32'h40; bus.MemValid = 1; #1;
    n_chk++; if (bus.PCWrite !== 1'b0 || bus.MemEn !== 1'b0) $display("FAIL fetch_c0: got pcw=%b en=%b want 0 0", bus.PCWrite, bus.MemEn); else n_pass++;
    @(negedge Clk); #1;
    n_chk++; if (bus.MemEn !== 1'b1 || bus.MemWe !== 1'b0 || bus.MemAddr !== 32'h40) $display("FAIL fetch_c1: got en=%b we=%b addr=%h want 1 0 40", bus.MemEn, bus.MemWe, bus.MemAddr); else n_pass++;
    n_chk++; if (bus.PCWrite !== 1'b0 || bus.IFIDWrite !== 1'b0) $display("FAIL fetch_c1_freeze: got %b%b want 00", bus.PCWrite, bus.IFIDWrite); else n_pass++;
    @(negedge Clk); #1;
    n_chk++; if (bus.IFDone !== 1'b1 || bus.IFData !== 32'hA5A5_0040) $display("FAIL fetch_c2_done: got done=%b data=%h want 1 a5a50040", bus.IFDone, bus.IFData); else n_pass++;
    n_chk++; if (bus.MemEn !== 1'b0 || bus.PCWrite !== 1'b1) $display("FAIL fetch_c2_en_pcw: got en=%b pcw=%b want 0 1", bus.MemEn, bus.PCWrite); else n_pass++;
    @(negedge Clk); bus.IFReq = 0; bus.MemValid = 0; #1;
    n_chk++; if (bus.IFDone !== 1'b0 || bus.MemEn !== 1'b0) $display("FAIL fetch_c3: got done=%b en=%b want 0 0", bus.IFDone, bus.MemEn); else n_pass++;
  endtask

  task automatic test_simultaneous();
    @(negedge Clk);
    bus.IFReq = 1; bus.IFAddr = 32'h80; bus.DReq = 1; bus.DWrite = 0; bus.DAddr = 32'h200; bus.MemValid = 1; #1;
    n_chk++; if (bus.MemStall !== 1'b1) $display("FAIL simul_c0_stall: got %b want 1", bus.MemStall); else n_pass++;
    @(negedge Clk); #1;
    n_chk++; if (bus.MemEn !== 1'b1 || bus.MemAddr !== 32'h200 || bus.MemWe !== 1'b0) $display("FAIL simul_c1_dgrant: got en=%b addr=%h we=%b want 1 200 0", bus.MemEn, bus.MemAddr, bus.MemWe); else n_pass++;
    @(negedge Clk); #1;
    n_chk++; if (bus.DDone !== 1'b1 || bus.IFDone !== 1'b0 || bus.DRData !== 32'hA5A5_0200) $display("FAIL simul_c2_ddone: got dd=%b id=%b rd=%h want 1 0 a5a50200", bus.DDone, bus.IFDone, bus.DRData); else n_pass++;
    n_chk++; if (bus.PCWrite !== 1'b0 || bus.MemStall !== 1'b0) $display("FAIL simul_c2_freeze: got pcw=%b stall=%b want 0 0", bus.PCWrite, bus.MemStall); else n_pass++;
    @(negedge Clk); bus.DReq = 0; #1;
    n_chk++; if (bus.MemEn !== 1'b0 || bus.DDone !== 1'b0) $display("FAIL simul_c3_idle: got en=%b dd=%b want 0 0", bus.MemEn, bus.DDone); else n_pass++;
    @(negedge Clk); #1;
    n_chk++; if (bus.MemEn !== 1'b1 || bus.MemAddr !== 32'h80) $display("FAIL simul_c4_igrant: got en=%b addr=%h want 1 80", bus.MemEn, bus.MemAddr); else n_pass++;
    @(negedge Clk); #1;
    n_chk++; if (bus.IFDone !== 1'b1 || bus.IFData !== 32'hA5A5_0080 || bus.PCWrite !== 1'b1) $display("FAIL simul_c5_idone: got id=%b data=%h pcw=%b want 1 a5a50080 1", bus.IFDone, bus.IFData, bus.PCWrite); else n_pass++;
    @(negedge Clk); idle_inputs();
  endtask

  task automatic test_store_wait();
    @(negedge Clk);
    bus.DReq = 1; bus.DWrite = 1; bus.DAddr = 32'h100; bus.DWData = 32'hDEAD_BEEF; bus.MemValid = 0; #1;
    n_chk++; if (bus.MemStall !== 1'b1 || bus.MemEn !== 1'b0 || bus.PCWrite !== 1'b0) $display("FAIL store_c0: got stall=%b en=%b pcw=%b want 1 0 0", bus.MemStall, bus.MemEn, bus.PCWrite); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      if (k == 4) bus.MemValid = 1;
      #1;
      n_chk++; if ({bus.MemEn, bus.MemWe, bus.MemStall, bus.DDone} !== 4'b1110) $display("FAIL store_busy_c%0d: got en,we,stall,dd=%b want 1110", k, {bus.MemEn, bus.MemWe, bus.MemStall, bus.DDone}); else n_pass++;
      n_chk++; if (bus.MemAddr !== 32'h100 || bus.MemWData !== 32'hDEAD_BEEF) $display("FAIL store_bus_c%0d: got %h %h want 100 deadbeef", k, bus.MemAddr, bus.MemWData); else n_pass++;
    end
    @(negedge Clk); #1;
    n_chk++; if (bus.DDone !== 1'b1 || bus.MemEn !== 1'b0 || bus.MemStall !== 1'b0) $display("FAIL store_c5: got dd=%b en=%b stall=%b want 1 0 0", bus.DDone, bus.MemEn, bus.MemStall); else n_pass++;
    n_chk++; if (bus.DRData !== 32'hA5A5_0200) $display("FAIL store_drdata_kept: got %h want a5a50200", bus.DRData); else n_pass++;
    @(negedge Clk); idle_inputs(); #1;
    n_chk++; if (bus.DDone !== 1'b0) $display("FAIL store_c6_pulse: got %b want 0", bus.DDone); else n_pass++;
  endtask

  task automatic test_stray_valid();
    @(negedge Clk); bus.MemValid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk); #1;
      n_chk++; if ({bus.IFDone, bus.DDone, bus.MemEn} !== 3'b000) $display("FAIL stray_c%0d: got idone,ddone,en=%b want 000", k, {bus.IFDone, bus.DDone, bus.MemEn}); else n_pass++;
    end
    n_chk++; if (bus.IFData !== 32'hA5A5_0080 || bus.DRData !== 32'hA5A5_0200) $display("FAIL stray_data: got %h %h want a5a50080 a5a50200", bus.IFData, bus.DRData); else n_pass++;
    @(negedge Clk); idle_inputs();
  endtask

  task automatic test_starvation();
    int dd_cnt;
    bit got_i;
    dd_cnt = 0; got_i = 0;
    @(negedge Clk);
    bus.IFReq = 1; bus.IFAddr = 32'h300; bus.DReq = 1; bus.DWrite = 0; bus.DAddr = 32'h400; bus.MemValid = 1;
    for (int c = 0; c < 60 && !got_i; c++) begin
      @(negedge Clk); #1;
      if (bus.DDone === 1'b1) begin
        dd_cnt++;
        bus.DAddr = bus.DAddr + 32'h4;
      end
      if (bus.IFDone === 1'b1) got_i = 1;
    end
    n_chk++; if (got_i !== 1'b1) $display("FAIL starve_timeout: got ifdone_seen=%b want 1", got_i); else n_pass++;
    n_chk++; if (dd_cnt != 4) $display("FAIL starve_ddone_count: got %0d want 4", dd_cnt); else n_pass++;
    n_chk++; if (bus.IFData !== 32'hA5A5_0300 || bus.DRData !== 32'hA5A5_040C) $display("FAIL starve_data: got %h %h want a5a50300 a5a5040c", bus.IFData, bus.DRData); else n_pass++;
    n_chk++; if (dut.starve_q !== 3'd0) $display("FAIL starve_cnt_cleared: got %0d want 0", dut.starve_q); else n_pass++;
    @(negedge Clk); idle_inputs();
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    @(negedge Clk); bus.DReq = 1; bus.DWrite = 0; bus.DAddr = 32'h500; bus.MemValid = 0;
    @(negedge Clk); #1;
    n_chk++; if (bus.MemEn !== 1'b1) $display("FAIL rstmid_c1_en: got %b want 1", bus.MemEn); else n_pass++;
    @(negedge Clk); Rst_n = 1'b0; #1;
    n_chk++; if (bus.MemEn !== 1'b0 || bus.DDone !== 1'b0 || bus.MemAddr !== 32'h0) $display("FAIL rstmid_abort: got en=%b dd=%b addr=%h want 0 0 0", bus.MemEn, bus.DDone, bus.MemAddr); else n_pass++;
    n_chk++; if (bus.IFData !== 32'h0 || bus.DRData !== 32'h0) $display("FAIL rstmid_data: got %h %h want 0 0", bus.IFData, bus.DRData); else n_pass++;
    @(negedge Clk); Rst_n = 1'b1; bus.MemValid = 1; #1;
    n_chk++; if (bus.DDone !== 1'b0 || bus.MemEn !== 1'b0) $display("FAIL rstmid_release: got dd=%b en=%b want 0 0", bus.DDone, bus.MemEn); else n_pass++;
    @(negedge Clk); #1;
    n_chk++; if (bus.MemEn !== 1'b1 || bus.MemAddr !== 32'h500) $display("FAIL rstmid_regrant: got en=%b addr=%h want 1 500", bus.MemEn, bus.MemAddr); else n_pass++;
    @(negedge Clk); #1;
    n_chk++; if (bus.DDone !== 1'b1 || bus.DRData !== 32'hA5A5_0500) $display("FAIL rstmid_ddone: got dd=%b rd=%h want 1 a5a50500", bus.DDone, bus.DRData); else n_pass++;
    @(negedge Clk); idle_inputs();
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store_wait();
    test_stray_valid();
    test_starvation();
    test_reset_mid();
    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end
endmodule
